// File: rtl/traj_pkg.sv
// rtl/traj_pkg.sv - shared trajectory memory constants, colours and draw FSM states
package traj_pkg;

    localparam int TRAJ_DEPTH  = 301;
    localparam int TRAJ_ADDR_W = 9;
    localparam int TRAJ_DATA_W = 19;
    localparam int PIX_LIMIT   = 307200;

    localparam logic [7:0] COLOR_TRAJ  = 8'hE0;
    localparam logic [7:0] COLOR_BLACK = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT1,
        ST_WAIT2,
        ST_EMIT,
        ST_FINISH
    } draw_state_t;

endpackage

// File: rtl/trajectory_draw_reader.sv
// rtl/trajectory_draw_reader.sv - frame-start sweep of trajectory RAM into framebuffer pixel writes (option: TRAJ_BOUNDS_CHECK_EN)
module trajectory_draw_reader
    import traj_pkg::*;
#(
    parameter int         DEPTH  = TRAJ_DEPTH,
    parameter int         ADDR_W = TRAJ_ADDR_W,
    parameter int         DATA_W = TRAJ_DATA_W,
    parameter logic [7:0] COLOR  = COLOR_TRAJ
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_num_entries,
    output logic [ADDR_W-1:0] o_rd_draw_add,
    input  logic [DATA_W-1:0] i_rd_draw_out,
    output logic [DATA_W-1:0] o_pix_addr,
    output logic [7:0]        o_pix_color,
    output logic              o_pix_valid,
    input  logic              i_pix_ready,
`ifdef TRAJ_BOUNDS_CHECK_EN
    output logic [ADDR_W-1:0] o_skip_count,
`endif
    output logic              o_busy,
    output logic              o_done
);

    draw_state_t       r_state;
    draw_state_t       w_next;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_limit;
    logic [ADDR_W-1:0] w_start_limit;
    logic              w_last;
    logic              w_oob;

    // Slot count is clamped so the sweep can never read past the last RAM slot.
    assign w_start_limit = (i_num_entries > ADDR_W'(DEPTH)) ? ADDR_W'(DEPTH) : i_num_entries;
    // The current slot is the final one; idx stops here instead of running to limit.
    assign w_last        = ((r_idx + ADDR_W'(1)) == r_limit);

`ifdef TRAJ_BOUNDS_CHECK_EN
    assign w_oob = (i_rd_draw_out >= DATA_W'(PIX_LIMIT));
`else
    assign w_oob = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // Next-state and handshake outputs; start is only honoured from IDLE.
    always_comb begin
        w_next      = r_state;
        o_pix_valid = 1'b0;
        o_pix_color = COLOR_BLACK;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_start) w_next = (w_start_limit == '0) ? ST_FINISH : ST_ISSUE;
            end
            ST_ISSUE: w_next = ST_WAIT1;
            ST_WAIT1: w_next = ST_WAIT2;
            ST_WAIT2: begin
                if (w_oob) w_next = w_last ? ST_FINISH : ST_ISSUE;
                else       w_next = ST_EMIT;
            end
            ST_EMIT: begin
                o_pix_valid = 1'b1;
                o_pix_color = COLOR;
                if (i_pix_ready) w_next = w_last ? ST_FINISH : ST_ISSUE;
            end
            ST_FINISH: begin
                o_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Sweep datapath: latch limit at start, drive the read address, capture data, step idx.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_idx         <= '0;
            r_limit       <= '0;
            o_rd_draw_add <= '0;
            o_pix_addr    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_limit <= w_start_limit;
                        r_idx   <= '0;
                    end
                end
                ST_ISSUE: o_rd_draw_add <= r_idx;
                ST_WAIT2: begin
                    if (!w_oob)       o_pix_addr <= i_rd_draw_out;
                    else if (!w_last) r_idx      <= r_idx + ADDR_W'(1);
                end
                ST_EMIT: begin
                    if (i_pix_ready && !w_last) r_idx <= r_idx + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef TRAJ_BOUNDS_CHECK_EN
    // Count of out-of-range entries dropped during the most recent sweep.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)                          o_skip_count <= '0;
        else if (r_state == ST_IDLE && i_start) o_skip_count <= '0;
        else if (r_state == ST_WAIT2 && w_oob)  o_skip_count <= o_skip_count + ADDR_W'(1);
    end
`endif

endmodule

// File: tb/tb_trajectory_draw_reader.sv
// tb/tb_trajectory_draw_reader.sv - self-checking bench for trajectory_draw_reader with a behavioural RAM and reference model
module tb_trajectory_draw_reader;
    import traj_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        pix_ready = 1'b1;
    logic [8:0]  num_entries = '0;
    logic [8:0]  rd_add;
    logic [18:0] rd_q;
    logic [18:0] pix_addr;
    logic [7:0]  pix_color;
    logic        pix_valid;
    logic        busy;
    logic        done;
`ifdef TRAJ_BOUNDS_CHECK_EN
    logic [8:0]  skip_count;
`endif

    always #5 clk = ~clk;

    trajectory_draw_reader dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_start       (start),
        .i_num_entries (num_entries),
        .o_rd_draw_add (rd_add),
        .i_rd_draw_out (rd_q),
        .o_pix_addr    (pix_addr),
        .o_pix_color   (pix_color),
        .o_pix_valid   (pix_valid),
        .i_pix_ready   (pix_ready),
`ifdef TRAJ_BOUNDS_CHECK_EN
        .o_skip_count  (skip_count),
`endif
        .o_busy        (busy),
        .o_done        (done)
    );

    // RAM: registered address (inside the reader) plus an output register here.
    logic [18:0] mem [0:300];
    always @(posedge clk) rd_q <= (rd_add <= 9'd300) ? mem[rd_add] : 19'bx;

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Monitor state, edges counted relative to the edge that samples start (E0).
    int          t_e0;
    bit          mon_en = 1'b0;
    logic [18:0] hs_addr[$];
    int          hs_edge[$];
    int          first_valid, done_edge, done_cnt, busy_cnt, stab_viol, col_bad, valid_cnt, max_add;
    bit          prev_stall;
    logic [18:0] prev_addr;
    int          rmode = 0;
    int          low_cnt = 0;

    logic [18:0] exp_q[$];
    int          exp_skip;

    always begin : mon
        int k;
        @(negedge clk);
        #1;
        if (mon_en && !rst) begin
            k = (int'($time) - 6 - t_e0) / 10;
            if (pix_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = k;
                if (pix_ready) begin
                    hs_addr.push_back(pix_addr);
                    hs_edge.push_back(k + 1);
                    if (pix_color !== 8'hE0) col_bad++;
                end
            end
            if (prev_stall && (!pix_valid || pix_addr !== prev_addr)) stab_viol++;
            prev_stall = pix_valid && !pix_ready;
            prev_addr  = pix_addr;
            if (done) begin
                done_cnt++;
                done_edge = k;
            end
            if (busy) busy_cnt++;
            if (int'(rd_add) > max_add) max_add = int'(rd_add);
        end
    end

    initial begin : ready_drv
        forever begin
            @(negedge clk);
            case (rmode)
                1: begin
                    if (hs_addr.size() == 1 && pix_valid && low_cnt < 5) begin
                        pix_ready = 1'b0;
                        low_cnt++;
                    end else pix_ready = 1'b1;
                end
                2:       pix_ready = ($urandom_range(0, 3) != 0);
                default: pix_ready = 1'b1;
            endcase
        end
    end

    task automatic build_exp(input int n);
        int lim;
        lim = (n > 301) ? 301 : n;
        exp_q.delete();
        exp_skip = 0;
        for (int i = 0; i < lim; i++) begin
`ifdef TRAJ_BOUNDS_CHECK_EN
            if (mem[i] >= 19'd307200) exp_skip++;
            else exp_q.push_back(mem[i]);
`else
            exp_q.push_back(mem[i]);
`endif
        end
    endtask

    task automatic clear_mon();
        hs_addr.delete();
        hs_edge.delete();
        first_valid = -1; done_edge = -1; done_cnt = 0; busy_cnt = 0;
        stab_viol = 0; col_bad = 0; valid_cnt = 0; max_add = 0; prev_stall = 1'b0;
    endtask

    task automatic begin_sweep(input int n);
        @(negedge clk);
        build_exp(n);
        clear_mon();
        t_e0        = int'($time) + 5;
        mon_en      = 1'b1;
        start       = 1'b1;
        num_entries = 9'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_sweep(input int budget, input bit poke);
        int i;
        i = 0;
        while (done_cnt == 0 && i < budget) begin
            @(negedge clk);
            i++;
            if (poke && i == 10) begin
                start       = 1'b1;
                num_entries = 9'($urandom_range(1, 5));
            end
            if (poke && i == 11) start = 1'b0;
        end
        check("sweep_done_within_budget", 32'(done_cnt > 0), 1);
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
    endtask

    task automatic compare_writes(input string tag);
        int mism;
        mism = 0;
        check({tag, "_write_count"}, hs_addr.size(), exp_q.size());
        for (int i = 0; i < hs_addr.size() && i < exp_q.size(); i++)
            if (hs_addr[i] !== exp_q[i]) mism++;
        check({tag, "_data_mismatches"}, mism, 0);
        check({tag, "_colour_errors"}, col_bad, 0);
        check({tag, "_stability_errors"}, stab_viol, 0);
        check({tag, "_done_pulses"}, done_cnt, 1);
`ifdef TRAJ_BOUNDS_CHECK_EN
        check({tag, "_skip_count"}, skip_count, exp_skip);
`endif
    endtask

    task automatic load_directed();
        mem[0] = 19'd100;
        mem[1] = 19'd641;
        mem[2] = 19'd307199;
    endtask

    initial begin : main
        for (int i = 0; i < 301; i++) mem[i] = 19'($urandom_range(0, 307199));

        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rd_add", rd_add, 0);
        check("rst_pix_addr", pix_addr, 0);
        check("rst_pix_color", pix_color, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Three-entry directed sweep, ready always high.
        load_directed();
        rmode = 0;
        begin_sweep(3);
        finish_sweep(100, 1'b0);
        compare_writes("basic");
        check("basic_first_valid_edge", first_valid, 3);
        check("basic_hs0_edge", hs_edge.size() > 0 ? hs_edge[0] : -1, 4);
        check("basic_hs1_edge", hs_edge.size() > 1 ? hs_edge[1] : -1, 8);
        check("basic_hs2_edge", hs_edge.size() > 2 ? hs_edge[2] : -1, 12);
        check("basic_done_edge", done_edge, 12);
        check("basic_busy_cycles", busy_cnt, 13);
        check("basic_busy_after", busy, 0);

        // Empty sweep.
        begin_sweep(0);
        finish_sweep(20, 1'b0);
        check("empty_valid_cycles", valid_cnt, 0);
        check("empty_done_edge", done_edge, 0);
        check("empty_busy_cycles", busy_cnt, 1);
        check("empty_done_pulses", done_cnt, 1);

        // Backpressure: ready low for five cycles while entry 1 is presented.
        rmode   = 1;
        low_cnt = 0;
        begin_sweep(3);
        finish_sweep(100, 1'b0);
        compare_writes("stall");
        check("stall_hs1_edge", hs_edge.size() > 1 ? hs_edge[1] : -1, 13);
        check("stall_hs2_edge", hs_edge.size() > 2 ? hs_edge[2] : -1, 17);
        check("stall_done_edge", done_edge, 17);
        check("stall_valid_cycles", valid_cnt, 8);
        check("stall_busy_cycles", busy_cnt, 18);

        // Over-large count clamps to the full RAM; extra start and count change mid-sweep.
        for (int i = 0; i < 301; i++) mem[i] = 19'($urandom_range(0, 307199));
        rmode = 2;
        begin_sweep(400);
        finish_sweep(20000, 1'b1);
        compare_writes("full");
        check("full_max_rd_add", max_add, 300);

        // Random sweeps with arbitrary 19-bit data.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 32; i++) mem[i] = 19'($urandom);
            begin_sweep($urandom_range(1, 24));
            finish_sweep(2000, 1'b0);
            compare_writes($sformatf("rand%0d", r));
        end

        // Reset during WAIT2 of entry 1.
        load_directed();
        rmode = 0;
        begin_sweep(3);
        repeat (6) @(negedge clk);
        check("midrst_busy_before", busy, 1);
        check("midrst_writes_before", hs_addr.size(), 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_rd_add", rd_add, 0);
        check("midrst_pix_addr", pix_addr, 0);
        check("midrst_pix_color", pix_color, 0);
        check("midrst_pix_valid", pix_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        clear_mon();
        repeat (12) @(negedge clk);
        check("postrst_valid_cycles", valid_cnt, 0);
        check("postrst_busy_cycles", busy_cnt, 0);
        mon_en = 1'b0;
        begin_sweep(3);
        finish_sweep(100, 1'b0);
        compare_writes("restart");
        check("restart_hs0_edge", hs_edge.size() > 0 ? hs_edge[0] : -1, 4);
        check("restart_done_edge", done_edge, 12);

`ifdef TRAJ_BOUNDS_CHECK_EN
        // Out-of-range slot is skipped.
        load_directed();
        mem[1] = 19'd307200;
        begin_sweep(3);
        finish_sweep(100, 1'b0);
        compare_writes("bounds");
        check("bounds_write_count", hs_addr.size(), 2);
        check("bounds_skip_count", skip_count, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
